// File: rtl/rom_wave_reader.sv
// Phase-accumulator address generator that sweeps a waveform ROM and retimes
// the returned words into a registered sample stream with completion signalling.
module rom_wave_reader #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int PHASE_WIDTH = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   single,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic [ADDR_WIDTH-1:0]  phase_offset,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    output logic                   rom_clk_en,
    input  logic [DATA_WIDTH-1:0]  rom_data,
    output logic [DATA_WIDTH-1:0]  sample,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] fw_q;
    logic [ADDR_WIDTH-1:0]  off_q;
    logic                   single_q;
    logic [ROM_LATENCY-1:0] vld_pipe;
    logic [ROM_LATENCY:0]   vld_shift;
    logic [PHASE_WIDTH:0]   phase_sum;
    logic                   wrap;
    logic                   accept;
    logic                   issue;
    logic                   last_issue;

    // Carry-out of the accumulator marks one full pass through the table.
    assign phase_sum  = {1'b0, phase} + {1'b0, fw_q};
    assign wrap       = phase_sum[PHASE_WIDTH];
    assign accept     = (state == IDLE) && start && (freq_word != '0);
    assign issue      = (state == RUN);
    assign last_issue = issue && (stop || (single_q && wrap));
    assign vld_shift  = {vld_pipe, issue};

    assign busy       = (state != IDLE);
    assign rom_clk_en = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // done fires in the DRAIN cycle that carries the final sample.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN: begin
                if (sample_valid && (vld_pipe == '0)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rom_addr is registered so the address for a RUN cycle is already on the
    // bus during that cycle; the first one is loaded on the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            fw_q     <= '0;
            off_q    <= '0;
            single_q <= 1'b0;
            rom_addr <= '0;
        end else if (accept) begin
            phase    <= '0;
            fw_q     <= freq_word;
            off_q    <= phase_offset;
            single_q <= single;
            rom_addr <= phase_offset;
        end else if (issue) begin
            phase <= phase_sum[PHASE_WIDTH-1:0];
            if (!last_issue)
                rom_addr <= phase_sum[PHASE_WIDTH-1 -: ADDR_WIDTH] + off_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe     <= '0;
            sample_valid <= 1'b0;
            sample       <= '0;
        end else begin
            vld_pipe     <= vld_shift[ROM_LATENCY-1:0];
            sample_valid <= vld_pipe[ROM_LATENCY-1];
            if (vld_pipe[ROM_LATENCY-1])
                sample <= rom_data;
        end
    end

endmodule

// File: tb/tb_rom_wave_reader.sv
// Bench for rom_wave_reader: two instances (ROM latency 1 and 2) with ROM
// models, directed sweeps plus randomized sweeps against a table-pass model.
module tb_rom_wave_reader;

    localparam int AW = 4;
    localparam int PW = 8;
    localparam int DW = 8;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           start;
    logic [1:0]           stop;
    logic                 single;
    logic [PW-1:0]        freq_word;
    logic [AW-1:0]        phase_offset;
    logic [1:0][AW-1:0]   rom_addr;
    logic [1:0]           rom_clk_en;
    logic [1:0][DW-1:0]   rom_data;
    logic [1:0][DW-1:0]   sample;
    logic [1:0]           sample_valid;
    logic [1:0]           busy;
    logic [1:0]           done;

    logic [DW-1:0]        rom_mem [16];
    logic [DW-1:0]        rom_s1;
    logic [DW-1:0]        last_sample [2];
    int                   exp_q [$];
    int                   n_cmp = 0;
    int                   n_err = 0;

    rom_wave_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ROM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .stop(stop[0]), .single(single),
        .freq_word(freq_word), .phase_offset(phase_offset), .rom_addr(rom_addr[0]),
        .rom_clk_en(rom_clk_en[0]), .rom_data(rom_data[0]), .sample(sample[0]),
        .sample_valid(sample_valid[0]), .busy(busy[0]), .done(done[0]));

    rom_wave_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ROM_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .stop(stop[1]), .single(single),
        .freq_word(freq_word), .phase_offset(phase_offset), .rom_addr(rom_addr[1]),
        .rom_clk_en(rom_clk_en[1]), .rom_data(rom_data[1]), .sample(sample[1]),
        .sample_valid(sample_valid[1]), .busy(busy[1]), .done(done[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROMs: one with a single read register, one with an output register too.
    always @(posedge clk) begin
        if (rom_clk_en[0]) rom_data[0] <= rom_mem[rom_addr[0]];
        if (rom_clk_en[1]) begin
            rom_s1      <= rom_mem[rom_addr[1]];
            rom_data[1] <= rom_s1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Address list of one sweep: top nibble of phase plus offset, ending on
    // the stop cycle or, in single mode, on the cycle whose increment overflows.
    function automatic void model(input int fw, input int off, input bit sgl, input int stop_at);
        int ph;
        ph = 0;
        exp_q.delete();
        for (int k = 1; k <= 1000; k++) begin
            exp_q.push_back(((ph / 16) + off) % 16);
            if (k == stop_at) break;
            if (sgl && (ph + fw > 255)) break;
            ph = (ph + fw) % 256;
        end
    endfunction

    // Entered and left at posedge+1.
    task automatic run_sweep(input int d, input int fw, input int off, input bit sgl,
                             input int stop_at, input int inj);
        int  lat, n, ea;
        bit  esv;
        logic [DW-1:0] es;
        string t;
        lat = d + 1;
        model(fw, off, sgl, stop_at);
        n = exp_q.size();
        single       = sgl;
        freq_word    = fw[PW-1:0];
        phase_offset = off[AW-1:0];
        start[d]     = 1'b1;
        @(posedge clk); #1;
        start[d]     = 1'b0;
        freq_word    = PW'($urandom_range(1, 255));
        phase_offset = AW'($urandom);
        single       = 1'($urandom);
        for (int k = 1; k <= n + lat + 3; k++) begin
            if (k == stop_at) stop[d] = 1'b1;
            if (k == inj && k < n) begin
                start[d]     = 1'b1;
                freq_word    = PW'($urandom_range(1, 255));
                phase_offset = AW'($urandom);
            end
            @(negedge clk);
            t   = $sformatf("d%0d fw%0h off%0h c%0d", d, fw, off, k);
            ea  = (k <= n) ? exp_q[k-1] : exp_q[n-1];
            esv = (k >= lat + 2) && (k <= n + lat + 1);
            if (esv) last_sample[d] = rom_mem[exp_q[k-lat-2]];
            es  = last_sample[d];
            check({t, " busy"}, 32'(busy[d]), 32'(k <= n + lat + 1));
            check({t, " clk_en"}, 32'(rom_clk_en[d]), 32'(k <= n + lat + 1));
            check({t, " addr"}, 32'(rom_addr[d]), 32'(ea));
            check({t, " valid"}, 32'(sample_valid[d]), 32'(esv));
            check({t, " sample"}, 32'(sample[d]), 32'(es));
            check({t, " done"}, 32'(done[d]), 32'(k == n + lat + 1));
            @(posedge clk); #1;
            stop[d]  = 1'b0;
            start[d] = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag, input int cycles, input bit pulse_start, input bit pulse_stop);
        for (int c = 0; c < cycles; c++) begin
            for (int d = 0; d < 2; d++) begin
                start[d] = pulse_start && (c == 0);
                stop[d]  = pulse_stop && (c == 0);
            end
            freq_word = '0;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("%s d%0d c%0d busy", tag, d, c), 32'(busy[d]), 32'd0);
                check($sformatf("%s d%0d c%0d valid", tag, d, c), 32'(sample_valid[d]), 32'd0);
                check($sformatf("%s d%0d c%0d done", tag, d, c), 32'(done[d]), 32'd0);
            end
            @(posedge clk); #1;
            start = '0;
            stop  = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = DW'($urandom);
        rst_n = 1'b0; start = '0; stop = '0; single = 1'b0;
        freq_word = '0; phase_offset = '0;
        last_sample[0] = '0; last_sample[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset d%0d busy", d), 32'(busy[d]), 32'd0);
            check($sformatf("reset d%0d addr", d), 32'(rom_addr[d]), 32'd0);
            check($sformatf("reset d%0d clk_en", d), 32'(rom_clk_en[d]), 32'd0);
            check($sformatf("reset d%0d sample", d), 32'(sample[d]), 32'd0);
            check($sformatf("reset d%0d valid", d), 32'(sample_valid[d]), 32'd0);
            check($sformatf("reset d%0d done", d), 32'(done[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep(0, 8'h10, 0, 1'b1, 0, 0);       // full single pass, addresses 0..F
        run_sweep(0, 8'h10, 4'hE, 1'b1, 0, 0);    // offset wraps the address
        run_sweep(1, 8'h08, 0, 1'b0, 6, 0);       // continuous, stop in 6th RUN cycle
        run_sweep(0, 8'h10, 3, 1'b1, 16, 0);      // stop lands on the wrap cycle
        run_sweep(0, 8'h20, 5, 1'b1, 0, 3);       // start during RUN ignored
        run_sweep(1, 8'h30, 7, 1'b1, 0, 2);
        check_idle("fw0", 4, 1'b1, 1'b0);
        check_idle("stop_idle", 3, 1'b0, 1'b1);

        // Reset with a sample in flight on the latency-1 instance.
        single = 1'b1; freq_word = 8'h10; phase_offset = 4'h2; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy[0]), 32'd0);
        check("midrst addr", 32'(rom_addr[0]), 32'd0);
        check("midrst clk_en", 32'(rom_clk_en[0]), 32'd0);
        check("midrst sample", 32'(sample[0]), 32'd0);
        check("midrst valid", 32'(sample_valid[0]), 32'd0);
        check("midrst done", 32'(done[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_sample[0] = '0; last_sample[1] = '0;
        check_idle("postrst", 8, 1'b0, 1'b0);
        run_sweep(0, 8'h10, 0, 1'b1, 0, 0);

        for (int it = 0; it < 30; it++) begin
            int  d, fw, off, sa, inj;
            bit  sgl;
            d   = int'($urandom_range(0, 1));
            fw  = int'($urandom_range(1, 255));
            off = int'($urandom_range(0, 15));
            sgl = 1'($urandom);
            sa  = sgl ? int'($urandom_range(0, 40)) : int'($urandom_range(1, 40));
            inj = int'($urandom_range(0, 5));
            run_sweep(d, fw, off, sgl, sa, inj);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
